// File: rtl/relu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : relu_pkg
// Description : Shared widths, FIFO entry type and packer state encoding for
//               the ReLU gradient packer.
// Revision    : 1.0 - initial release
// ============================================================================
package relu_pkg;

    localparam int FLOAT_W  = 32;
    localparam int PACKED_W = 64;

    typedef struct packed {
        logic               last;
        logic [FLOAT_W-1:0] data;
    } grad_entry_t;

    typedef enum logic [0:0] {
        LOW  = 1'b0,
        HIGH = 1'b1
    } pack_state_e;

    // Either-sign zero: everything except the sign bit is clear.
    function automatic logic is_float_zero(input logic [FLOAT_W-1:0] f);
        return (f[FLOAT_W-2:0] == '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/grad_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : grad_sync_fifo
// Description : Single-clock FIFO of grad_entry_t with full/empty/count and
//               a combinational head read.
// Revision    : 1.0 - initial release
// ============================================================================
module grad_sync_fifo
    import relu_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  grad_entry_t i_wdata,
    input  logic        i_pop,
    output grad_entry_t o_rdata,
    output logic        o_full,
    output logic        o_empty,
    output logic [AW:0] o_count
);

    localparam logic [AW:0] c_full_cnt = DEPTH[AW:0];

    grad_entry_t   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == c_full_cnt);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    // A full FIFO refuses the push even when a pop frees a slot this cycle.
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/relu_grad_packer.sv
`default_nettype none
// ============================================================================
// Module      : relu_grad_packer
// Description : Buffers 32-bit gradients and packs pairs into 64-bit beats,
//               zero-padding an odd final word. Optional macro
//               RELU_ZERO_STATS_EN adds the zero_count statistics port.
// Revision    : 1.0 - initial release
// ============================================================================
module relu_grad_packer
    import relu_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [FLOAT_W-1:0]  in_data,
    input  logic                in_valid,
    input  logic                in_last,
    output logic                in_ready,
    output logic [PACKED_W-1:0] out_data,
    output logic                out_valid,
    output logic                out_last,
    input  logic                out_ready
`ifdef RELU_ZERO_STATS_EN
    ,
    output logic [FLOAT_W-1:0]  zero_count
`endif
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] c_full_cnt = DEPTH[AW:0];

    pack_state_e         r_state;
    pack_state_e         w_state_nxt;
    logic [FLOAT_W-1:0]  r_lo;
    logic [PACKED_W-1:0] r_out_data;
    logic                r_out_valid;
    logic                r_out_last;

    grad_entry_t         w_wentry;
    grad_entry_t         w_head;
    logic                w_full;
    logic                w_empty;
    logic [AW:0]         w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_out_free;

    assign w_wentry   = '{last: in_last, data: in_data};
    assign w_push     = in_valid && !w_full;
    assign in_ready   = (w_count < c_full_cnt) && !reset;
    assign w_out_free = !r_out_valid || out_ready;
    // A non-last word entering LOW only loads lo, so it never waits on the output.
    assign w_pop      = !w_empty &&
                        (((r_state == LOW) && !w_head.last) || w_out_free);

    grad_sync_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_wdata (w_wentry),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= LOW;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_pop) begin
            if (r_state == HIGH) begin
                w_state_nxt = LOW;
            end else if (!w_head.last) begin
                w_state_nxt = HIGH;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lo        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_pop) begin
            if (r_state == HIGH) begin
                r_out_data  <= {w_head.data, r_lo};
                r_out_valid <= 1'b1;
                r_out_last  <= w_head.last;
            end else if (w_head.last) begin
                r_out_data  <= {{FLOAT_W{1'b0}}, w_head.data};
                r_out_valid <= 1'b1;
                r_out_last  <= 1'b1;
            end else begin
                r_lo <= w_head.data;
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;

`ifdef RELU_ZERO_STATS_EN
    logic [FLOAT_W-1:0] r_zero_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_zero_count <= '0;
        end else if (w_push && is_float_zero(in_data) && (r_zero_count != '1)) begin
            r_zero_count <= r_zero_count + 1'b1;
        end
    end

    assign zero_count = r_zero_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_relu_grad_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_relu_grad_packer
// Description : Directed and randomized self-checking bench for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_relu_grad_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        out_ready;
`ifdef RELU_ZERO_STATS_EN
    logic [31:0] zero_count;
`endif

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_acc   = 0;
    logic [64:0] cap[$];

    always #5 clk = ~clk;

    relu_grad_packer #(.DEPTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready)
`ifdef RELU_ZERO_STATS_EN
        ,
        .zero_count (zero_count)
`endif
    );

    // Inputs change only just after a rising edge, so the falling edge sees
    // exactly the values the next rising edge will act on.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            cap.push_back({out_last, out_data});
        end
    end

    task automatic push_word(input logic [31:0] d, input logic l);
        bit got = 1'b0;
        int k   = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        while (!got && k < 200) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            k++;
        end
        in_valid = 1'b0;
        if (!got) begin
            n_total++;
            $display("FAIL push_timeout word=%h", d);
        end else begin
            n_acc++;
        end
    endtask

    task automatic wait_beats(input int n, input int budget);
        int k = 0;
        while (cap.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        if (cap.size() < n) begin
            n_total++;
            $display("FAIL beat_timeout got=%0d want=%0d", cap.size(), n);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b want=0", out_valid); else n_pass++;
        n_total++; if (out_last !== 1'b0) $display("FAIL rst_out_last got=%b want=0", out_last); else n_pass++;
        n_total++; if (out_data !== 64'h0) $display("FAIL rst_out_data got=%h want=0", out_data); else n_pass++;
        n_total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got=%b want=0", in_ready); else n_pass++;
`ifdef RELU_ZERO_STATS_EN
        n_total++; if (zero_count !== 32'h0) $display("FAIL rst_zero_count got=%h want=0", zero_count); else n_pass++;
`endif
        reset = 1'b0;
        @(negedge clk);
        n_total++; if (in_ready !== 1'b1) $display("FAIL rel_in_ready got=%b want=1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pair_latency();
        cap.delete();
        out_ready = 1'b1;
        push_word(32'h3F800000, 1'b0);
        push_word(32'h40000000, 1'b1);
        n_total++; if (out_valid !== 1'b0) $display("FAIL pair_early_valid got=%b want=0", out_valid); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b1) $display("FAIL pair_valid got=%b want=1", out_valid); else n_pass++;
        n_total++; if (out_data !== 64'h40000000_3F800000) $display("FAIL pair_data got=%h want=400000003f800000", out_data); else n_pass++;
        n_total++; if (out_last !== 1'b1) $display("FAIL pair_last got=%b want=1", out_last); else n_pass++;
        @(posedge clk);
        #1;
        n_total++; if (out_valid !== 1'b0) $display("FAIL pair_drop got=%b want=0", out_valid); else n_pass++;
    endtask

    task automatic test_odd_tail();
        cap.delete();
        out_ready = 1'b1;
        push_word(32'h11111111, 1'b0);
        push_word(32'h22222222, 1'b0);
        push_word(32'h33333333, 1'b1);
        wait_beats(2, 50);
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (cap.size() !== 2) begin
            $display("FAIL odd_count got=%0d want=2", cap.size());
        end else begin
            n_pass++;
            n_total++; if (cap[0] !== {1'b0, 32'h22222222, 32'h11111111}) $display("FAIL odd_beat0 got=%h want=0_22222222_11111111", cap[0]); else n_pass++;
            n_total++; if (cap[1] !== {1'b1, 32'h0, 32'h33333333}) $display("FAIL odd_beat1 got=%h want=1_00000000_33333333", cap[1]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [64:0] want;
        cap.delete();
        out_ready = 1'b0;
        n_acc     = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    push_word(32'hA000_0000 + 32'(i), (i == 19));
                end
            end
            begin
                repeat (40) @(posedge clk);
                #2;
                // Three words leave the FIFO (one beat held, one in lo), eight fill it.
                n_total++; if (in_ready !== 1'b0) $display("FAIL b2b_in_ready got=%b want=0", in_ready); else n_pass++;
                n_total++; if (n_acc !== 11) $display("FAIL b2b_accepted got=%0d want=11", n_acc); else n_pass++;
                n_total++; if (out_valid !== 1'b1) $display("FAIL b2b_stall_valid got=%b want=1", out_valid); else n_pass++;
                n_total++; if (out_data !== 64'hA0000001_A0000000) $display("FAIL b2b_stall_data got=%h want=a0000001a0000000", out_data); else n_pass++;
                out_ready = 1'b1;
            end
        join
        wait_beats(10, 100);
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (cap.size() !== 10) $display("FAIL b2b_count got=%0d want=10", cap.size()); else n_pass++;
        for (int i = 0; i < 10 && i < cap.size(); i++) begin
            want = {(i == 9), 32'hA000_0000 + 32'(2 * i + 1), 32'hA000_0000 + 32'(2 * i)};
            n_total++; if (cap[i] !== want) $display("FAIL b2b_beat%0d got=%h want=%h", i, cap[i], want); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_tensor();
        cap.delete();
        out_ready = 1'b1;
        push_word(32'hDEADBEEF, 1'b0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        n_total++; if (in_ready !== 1'b0) $display("FAIL mid_in_ready got=%b want=0", in_ready); else n_pass++;
        @(posedge clk);
        #1 reset = 1'b0;
        push_word(32'h01234567, 1'b0);
        push_word(32'h89ABCDEF, 1'b1);
        wait_beats(1, 50);
        repeat (5) @(posedge clk);
        #1;
        n_total++;
        if (cap.size() !== 1) begin
            $display("FAIL mid_count got=%0d want=1", cap.size());
        end else begin
            n_pass++;
            n_total++; if (cap[0] !== {1'b1, 32'h89ABCDEF, 32'h01234567}) $display("FAIL mid_beat got=%h want=1_89abcdef_01234567", cap[0]); else n_pass++;
        end
    endtask

`ifdef RELU_ZERO_STATS_EN
    task automatic test_zero_stats();
        pulse_reset();
        out_ready = 1'b1;
        push_word(32'h00000000, 1'b0);
        push_word(32'h80000000, 1'b0);
        push_word(32'h3F800000, 1'b1);
        n_total++; if (zero_count !== 32'd2) $display("FAIL zero_count got=%0d want=2", zero_count); else n_pass++;
        force dut.r_zero_count = 32'hFFFF_FFFE;
        #1;
        release dut.r_zero_count;
        push_word(32'h00000000, 1'b0);
        push_word(32'h80000000, 1'b1);
        n_total++; if (zero_count !== 32'hFFFF_FFFF) $display("FAIL zero_sat got=%h want=ffffffff", zero_count); else n_pass++;
    endtask
`endif

    task automatic test_random();
        logic [64:0] exp_q[$];
        logic [31:0] lo;
        logic [31:0] w;
        logic        l;
        bit          have = 1'b0;
        bit          done = 1'b0;
        cap.delete();
        lo = '0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    w = $urandom;
                    l = (i == 999) || ($urandom_range(0, 4) == 0);
                    if (have) begin
                        exp_q.push_back({l, w, lo});
                        have = 1'b0;
                    end else if (l) begin
                        exp_q.push_back({1'b1, 32'h0, w});
                    end else begin
                        lo   = w;
                        have = 1'b1;
                    end
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    push_word(w, l);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        wait_beats(exp_q.size(), 3000);
        repeat (5) @(posedge clk);
        #1;
        n_total++; if (cap.size() !== exp_q.size()) $display("FAIL rnd_count got=%0d want=%0d", cap.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++) begin
            n_total++; if (cap[i] !== exp_q[i]) $display("FAIL rnd_beat%0d got=%h want=%h", i, cap[i], exp_q[i]); else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_pair_latency();
        test_odd_tail();
        test_back_to_back();
        test_reset_mid_tensor();
`ifdef RELU_ZERO_STATS_EN
        test_zero_stats();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
